usb_stream_reader: RTL and testbench
====================================

Name: usb_stream_reader

Overview:
- Downstream consumer of the ADC capture block's register read port in streaming mode.
- On each stream_segment_available, issues back-to-back register read strobes at the ADC FIFO read address.
- Collects the returned bytes in a small credit-controlled buffer and presents them on a valid/ready byte stream toward the USB bulk endpoint logic.
- Replaces per-byte host register reads with hardware-paced segment bursts.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt; must match the register bus.
pFIFO_ADDR, 8'd3, register address of the ADC FIFO data port.
pREAD_LATENCY, 1, clk_usb cycles from reg_read high to reg_datai valid (1..3).
pBUF_DEPTH, 4, output buffer entries; power of two, at least pREAD_LATENCY+1.

Ports:
clk_usb  in  1  96 MHz system clock; all logic on its rising edge
reset_i  in  1  asynchronous active-high reset
enable  in  1  level; streaming allowed when high
segment_size  in  32  bytes per segment; sampled when a segment starts
stream_segment_available  in  1  level from the capture block; a segment is ready to read
reg_address  out  8  register address; pFIFO_ADDR whenever reg_read is high, else 0
reg_bytecnt  out  pBYTECNT_SIZE  byte index within the current segment, wrapping modulo 2^pBYTECNT_SIZE
reg_read  out  1  one-cycle read strobe per byte
reg_datai  in  8  read data from the capture block, valid pREAD_LATENCY cycles after reg_read
ep_data  out  8  stream byte
ep_valid  out  1  ep_data is valid
ep_ready  in  1  sink accepts the byte when ep_valid && ep_ready
ep_last  out  1  high with the final byte of a segment
busy  out  1  high outside IDLE
bytes_sent  out  32  bytes accepted by the sink since reset; wraps at 2^32
size_err  out  1  sticky; set when a segment starts with segment_size==0; cleared by reset only

Behaviour:
- Reset values: every output 0, FSM in IDLE, buffer empty, in-flight count 0.
- States:
  - IDLE: when enable && stream_segment_available && buffer empty, latch segment_size into remaining and go to READ.
  - IDLE with latched size 0: set size_err, stay in IDLE, issue no reads.
  - READ: assert reg_read in any cycle where remaining>0 and (occupancy + in_flight) < pBUF_DEPTH.
  - Each issued read: decrement remaining, increment reg_bytecnt after the strobe.
  - READ exit: when remaining reaches 0, go to DRAIN.
  - DRAIN: wait until in_flight==0 and the buffer is empty, then return to IDLE; reg_bytecnt returns to 0.
- Read pipeline:
  - A pREAD_LATENCY-deep shift register tags returning data.
  - The tagged byte is written into the buffer exactly pREAD_LATENCY cycles after its strobe.
  - The credit rule guarantees no overflow; a write into a full buffer is a design error and must be asserted in simulation.
- Buffer:
  - FIFO; head drives ep_data/ep_valid combinationally from registered storage.
  - Same-cycle push and pop leaves occupancy unchanged.
- Throughput: with ep_ready held high, one byte per cycle sustained after an initial latency of pREAD_LATENCY+1 cycles.
- ep_last:
  - A tag bit travels with the byte whose strobe took remaining from 1 to 0.
  - ep_last is high only while that byte is at the head.
- enable dropped mid-segment:
  - Stop issuing reads immediately and go to DRAIN.
  - Deliver all in-flight and buffered bytes; ep_last is not asserted.
  - Return to IDLE.
- stream_segment_available dropping mid-segment is ignored; the latched size governs.
- bytes_sent increments on each accepted handshake.
- Asynchronous reset mid-operation discards buffered and in-flight bytes; no ep_valid for 1 cycle after release.

Optional Feature:
USB_STREAM_READER_CKSUM_EN:
- When defined, each completed segment is followed by one extra ep byte: the XOR of all data bytes of that segment.
- ep_last moves from the last data byte to the checksum byte.
- The checksum byte counts in bytes_sent.
- It is not emitted for segments aborted by enable dropping.
- When undefined, there is no checksum logic and ep_last behaves as in Behaviour.

Test Plan:
- Streaming, ready high: segment_size=16, enable=1, available pulse, ep_ready=1 -> 16 strobes on consecutive cycles at address 3, bytecnt 0..15; ep bytes match the model; ep_last on byte 16; bytes_sent=16; busy low afterwards.
- Backpressure: segment_size=10, ep_ready toggled 1-0-0-1 -> no buffer overflow assertion; occupancy+in_flight never exceeds 4; all 10 bytes in order.
- Zero size: segment_size=0, available=1 -> no reg_read; size_err=1; busy=0.
- Abort: segment_size=100, enable drops after 20 strobes -> exactly 20 bytes delivered, none with ep_last; then IDLE.
- Reset mid-segment: assert reset_i during READ -> all outputs 0 the same cycle; the next segment starts cleanly at bytecnt 0.
- CKSUM_EN: data 0x01,0x02,0x04 -> 4th byte 0x07 with ep_last; bytes_sent=4.

Source files
------------

// File: rtl/usb_stream_reader.sv
// ============================================================================
// Module   : usb_stream_reader
// Function : Streams ADC FIFO segments over the register read port into a
//            credit-controlled buffer feeding a valid/ready USB byte stream.
//            Optional macro USB_STREAM_READER_CKSUM_EN appends an XOR
//            checksum byte after every completed segment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_stream_reader #(
  parameter int         pBYTECNT_SIZE = 7,
  parameter logic [7:0] pFIFO_ADDR    = 8'd3,
  parameter int         pREAD_LATENCY = 1,
  parameter int         pBUF_DEPTH    = 4
) (
  input  logic                     clk_usb,
  input  logic                     reset_i,
  input  logic                     enable,
  input  logic [31:0]              segment_size,
  input  logic                     stream_segment_available,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic                     reg_read,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               ep_data,
  output logic                     ep_valid,
  input  logic                     ep_ready,
  output logic                     ep_last,
  output logic                     busy,
  output logic [31:0]              bytes_sent,
  output logic                     size_err
);

  localparam int PTR_W = $clog2(pBUF_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [31:0]              remaining;
  logic [CNT_W-1:0]         in_flight;
  logic [CNT_W-1:0]         occupancy;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [7:0]               mem_data [pBUF_DEPTH];
  logic                     mem_last [pBUF_DEPTH];
  logic [pREAD_LATENCY-1:0] pipe_vld;
  logic [pREAD_LATENCY-1:0] pipe_last;

  logic       start;
  logic       start_ok;
  logic       credit_ok;
  logic       issue;
  logic       last_tag;
  logic       pipe_push;
  logic       push;
  logic [7:0] push_data;
  logic       push_last;
  logic       pop;
  logic       drain_done;

  assign start     = (state == S_IDLE) && enable && stream_segment_available &&
                     (occupancy == '0) && (in_flight == '0);
  assign start_ok  = start && (segment_size != 32'd0);
  // Buffered plus outstanding bytes must always fit in the buffer.
  assign credit_ok = (occupancy + in_flight) < CNT_W'(pBUF_DEPTH);
  assign issue     = (state == S_READ) && enable && (remaining != 32'd0) && credit_ok;
  assign pipe_push = pipe_vld[pREAD_LATENCY-1];
  assign pop       = ep_valid && ep_ready;

`ifdef USB_STREAM_READER_CKSUM_EN
  logic [7:0] cksum;
  logic       cksum_sent;
  logic       aborted;
  logic       cksum_push;

  assign last_tag   = 1'b0;
  assign cksum_push = (state == S_DRAIN) && !aborted && !cksum_sent &&
                      (in_flight == '0) && (occupancy < CNT_W'(pBUF_DEPTH));
  assign push       = pipe_push || cksum_push;
  assign push_data  = pipe_push ? reg_datai : cksum;
  assign push_last  = pipe_push ? pipe_last[pREAD_LATENCY-1] : 1'b1;
  assign drain_done = (in_flight == '0) && (occupancy == '0) && (aborted || cksum_sent);

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      cksum      <= 8'd0;
      cksum_sent <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (start_ok) begin
        cksum      <= 8'd0;
        cksum_sent <= 1'b0;
        aborted    <= 1'b0;
      end else begin
        if (pipe_push)                     cksum      <= cksum ^ reg_datai;
        if (cksum_push)                    cksum_sent <= 1'b1;
        if ((state == S_READ) && !enable)  aborted    <= 1'b1;
      end
    end
  end
`else
  assign last_tag   = 1'b1;
  assign push       = pipe_push;
  assign push_data  = reg_datai;
  assign push_last  = pipe_last[pREAD_LATENCY-1];
  assign drain_done = (in_flight == '0) && (occupancy == '0);
`endif

  // State register
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_READ;
      S_READ: begin
        if (!enable)                              state_nxt = S_DRAIN;
        else if (issue && (remaining == 32'd1))   state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    reg_read    = issue;
    reg_address = issue ? pFIFO_ADDR : 8'd0;
    busy        = (state != S_IDLE);
    ep_valid    = (occupancy != '0);
    ep_data     = ep_valid ? mem_data[rd_ptr] : 8'd0;
    ep_last     = ep_valid && mem_last[rd_ptr];
  end

  generate
    if (pREAD_LATENCY > 1) begin : g_pipe_deep
      always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
          pipe_vld  <= '0;
          pipe_last <= '0;
        end else begin
          pipe_vld  <= {pipe_vld[pREAD_LATENCY-2:0], issue};
          pipe_last <= {pipe_last[pREAD_LATENCY-2:0], issue && last_tag && (remaining == 32'd1)};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
          pipe_vld  <= '0;
          pipe_last <= '0;
        end else begin
          pipe_vld  <= issue;
          pipe_last <= issue && last_tag && (remaining == 32'd1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      remaining   <= 32'd0;
      reg_bytecnt <= '0;
      in_flight   <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bytes_sent  <= 32'd0;
      size_err    <= 1'b0;
    end else begin
      if (start && (segment_size == 32'd0)) size_err <= 1'b1;

      if (start_ok)   remaining <= segment_size;
      else if (issue) remaining <= remaining - 32'd1;

      if (issue)                                reg_bytecnt <= reg_bytecnt + pBYTECNT_SIZE'(1);
      else if ((state == S_DRAIN) && drain_done) reg_bytecnt <= '0;

      in_flight <= in_flight + CNT_W'(issue) - CNT_W'(pipe_push);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        bytes_sent <= bytes_sent + 32'd1;
      end
      if (push && !pop)      occupancy <= occupancy + CNT_W'(1);
      else if (!push && pop) occupancy <= occupancy - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_usb) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= push_last;
    end
  end

  // The credit rule makes a write into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk_usb) disable iff (reset_i)
                                  !(push && (occupancy == CNT_W'(pBUF_DEPTH))));

endmodule

`default_nettype wire

// File: tb/tb_usb_stream_reader.sv
// ============================================================================
// Module   : tb_usb_stream_reader
// Function : Directed self-checking bench for usb_stream_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_stream_reader;

  logic        clk_usb = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] segment_size = 32'd0;
  logic        stream_segment_available = 1'b0;
  logic [7:0]  reg_address;
  logic [6:0]  reg_bytecnt;
  logic        reg_read;
  logic [7:0]  reg_datai = 8'd0;
  logic [7:0]  ep_data;
  logic        ep_valid;
  logic        ep_ready = 1'b0;
  logic        ep_last;
  logic        busy;
  logic [31:0] bytes_sent;
  logic        size_err;

`ifdef USB_STREAM_READER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_sent = 0;
  logic [7:0] src [0:127];
  logic [8:0] rx_q [$];
  int         rx_cyc [$];
  int         st_bc [$];
  int         st_cyc [$];
  bit         addr_bad = 1'b0;
  bit         credit_bad = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;

  always #5 clk_usb = ~clk_usb;

  usb_stream_reader dut (
    .clk_usb                  (clk_usb),
    .reset_i                  (reset_i),
    .enable                   (enable),
    .segment_size             (segment_size),
    .stream_segment_available (stream_segment_available),
    .reg_address              (reg_address),
    .reg_bytecnt              (reg_bytecnt),
    .reg_read                 (reg_read),
    .reg_datai                (reg_datai),
    .ep_data                  (ep_data),
    .ep_valid                 (ep_valid),
    .ep_ready                 (ep_ready),
    .ep_last                  (ep_last),
    .busy                     (busy),
    .bytes_sent               (bytes_sent),
    .size_err                 (size_err)
  );

  // Capture-block model: data one cycle after the strobe, indexed by bytecnt.
  always @(posedge clk_usb) begin
    cyc <= cyc + 1;
    if (reg_read) reg_datai <= src[reg_bytecnt];
  end

  always @(negedge clk_usb) begin
    if (reg_read) begin
      st_bc.push_back(int'(reg_bytecnt));
      st_cyc.push_back(cyc);
      if (reg_address !== 8'd3) addr_bad = 1'b1;
    end else if (reg_address !== 8'd0) begin
      addr_bad = 1'b1;
    end
    if (ep_valid && ep_ready) begin
      rx_q.push_back({ep_last, ep_data});
      rx_cyc.push_back(cyc);
    end
    if (!reset_i && (int'(dut.occupancy) + int'(dut.in_flight) > 4)) credit_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic clear_q();
    rx_q.delete();
    rx_cyc.delete();
    st_bc.delete();
    st_cyc.delete();
  endtask

  task automatic start_seg(input int size);
    segment_size = 32'(size);
    stream_segment_available = 1'b1;
    tick();
    stream_segment_available = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit bp);
    int g = 0;
    while (busy && g < 500) begin
      if (bp) ep_ready = rdy_pat[g % 4];
      tick();
      g++;
    end
    ep_ready = 1'b1;
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_strobes(input string tag, input int n);
    check({tag, "_nstrobe"}, 32'(st_bc.size()), 32'(n));
    for (int i = 0; i < n && i < st_bc.size(); i++)
      check($sformatf("%s_bytecnt%0d", tag, i), 32'(st_bc[i]), 32'(i % 128));
  endtask

  task automatic check_stream(input string tag, input int n, input bit aborted);
    int         exp_n;
    logic [7:0] x;
    logic [8:0] e;
    exp_n = n + ((CK == 1 && !aborted) ? 1 : 0);
    x = 8'd0;
    check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < rx_q.size(); i++) begin
      if (i < n) begin
        e = {1'b0, src[i]};
        x = x ^ src[i];
        if (i == n - 1 && CK == 0 && !aborted) e[8] = 1'b1;
      end else begin
        e = {1'b1, x};
      end
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(e));
    end
    exp_sent += exp_n;
    check({tag, "_bytes_sent"}, bytes_sent, 32'(exp_sent));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) src[i] = 8'(i * 29 + 8'h5A);

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ep_valid", 32'(ep_valid), 32'd0);
    check("rst_reg_read", 32'(reg_read), 32'd0);
    check("rst_bytes_sent", bytes_sent, 32'd0);
    reset_i = 1'b0;
    tick();
    check("rel_size_err", 32'(size_err), 32'd0);
    check("rel_bytecnt", 32'(reg_bytecnt), 32'd0);
    check("rel_addr", 32'(reg_address), 32'd0);

    // Streaming with ep_ready high
    enable = 1'b1;
    ep_ready = 1'b1;
    clear_q();
    start_seg(16);
    check("s16_busy", 32'(busy), 32'd1);
    wait_idle("s16", 1'b0);
    check_strobes("s16", 16);
    check_stream("s16", 16, 1'b0);
    if (st_cyc.size() == 16 && rx_cyc.size() >= 16) begin
      check("s16_strobe_span", 32'(st_cyc[15] - st_cyc[0]), 32'd15);
      check("s16_latency", 32'(rx_cyc[0] - st_cyc[0]), 32'd2);
      check("s16_rx_span", 32'(rx_cyc[15] - rx_cyc[0]), 32'd15);
    end else begin
      check("s16_timing_avail", 32'd0, 32'd1);
    end
    check("s16_addr", 32'(addr_bad), 32'd0);
    check("s16_bytecnt_end", 32'(reg_bytecnt), 32'd0);

    // Backpressure with ep_ready pattern 1-0-0-1
    clear_q();
    start_seg(10);
    wait_idle("bp10", 1'b1);
    check_strobes("bp10", 10);
    check_stream("bp10", 10, 1'b0);
    check("bp10_credit", 32'(credit_bad), 32'd0);

    // Zero-size segment
    clear_q();
    segment_size = 32'd0;
    stream_segment_available = 1'b1;
    repeat (3) tick();
    stream_segment_available = 1'b0;
    tick();
    check("zero_nstrobe", 32'(st_bc.size()), 32'd0);
    check("zero_size_err", 32'(size_err), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);

    // Abort after 20 strobes
    clear_q();
    start_seg(100);
    begin
      int g = 0;
      while (st_bc.size() < 20 && g < 200) begin
        tick();
        g++;
      end
    end
    enable = 1'b0;
    wait_idle("abort", 1'b0);
    check_strobes("abort", 20);
    check_stream("abort", 20, 1'b1);
    check("abort_bytecnt", 32'(reg_bytecnt), 32'd0);

    // Reset in the middle of READ
    enable = 1'b1;
    clear_q();
    start_seg(50);
    repeat (4) tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset_i = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_reg_read", 32'(reg_read), 32'd0);
    check("mid_ep_valid", 32'(ep_valid), 32'd0);
    check("mid_bytes_sent", bytes_sent, 32'd0);
    check("mid_bytecnt", 32'(reg_bytecnt), 32'd0);
    check("mid_size_err", 32'(size_err), 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    check("post_rst_ep_valid", 32'(ep_valid), 32'd0);
    exp_sent = 0;
    clear_q();
    start_seg(5);
    wait_idle("after_rst", 1'b0);
    check_strobes("after_rst", 5);
    check_stream("after_rst", 5, 1'b0);

    // Checksum pattern 0x01, 0x02, 0x04
    src[0] = 8'h01;
    src[1] = 8'h02;
    src[2] = 8'h04;
    clear_q();
    start_seg(3);
    wait_idle("ck3", 1'b0);
    check_strobes("ck3", 3);
    check_stream("ck3", 3, 1'b0);
    check("final_addr", 32'(addr_bad), 32'd0);
    check("final_credit", 32'(credit_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
